// File: rtl/ps2_kbd_pkg.sv
// Shared scancode constants, parser state encoding and key event record
// for the PS/2 keyboard event queue.
package ps2_kbd_pkg;

   localparam logic [7:0] BAT    = 8'hAA;
   localparam logic [7:0] EXT    = 8'hE0;
   localparam logic [7:0] BRK    = 8'hF0;
   localparam logic [7:0] ACK    = 8'hFA;
   localparam logic [7:0] ECHO   = 8'hEE;
   localparam logic [7:0] RESEND = 8'hFE;
   localparam logic [7:0] PAUSE  = 8'hE1;

   typedef enum logic [2:0] {
      WAIT_BAT,
      IDLE,
      GOT_E0,
      GOT_F0,
      GOT_E0F0
   } parse_state_t;

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } key_evt_t;

   // Keyboard housekeeping replies that never represent a key in IDLE
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == ACK) || (b == ECHO) || (b == RESEND) || (b == PAUSE) ||
             (b == 8'h00) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module evt_sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 Set 2 scancode parser with key-down bitmap and queued make/break events.
// Define PS2_REPEAT_FILTER_EN to drop typematic repeats and orphan breaks from the queue.
module ps2_key_event_queue
   import ps2_kbd_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int PREFIX_TIMEOUT = 100000,
   parameter bit REQUIRE_BAT    = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          byte_valid,
   input  logic [7:0]                    byte_data,
   input  logic                          byte_err,
   output logic [511:0]                  key_down,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [8:0]                    evt_code,
   output logic                          evt_break,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic                          kbd_ready
);

   localparam int             TW       = $clog2(PREFIX_TIMEOUT + 1);
   localparam logic [TW-1:0]  TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

   parse_state_t  state;
   logic [TW-1:0] tmo_cnt;
   key_evt_t      evt_new;
   key_evt_t      head;
   logic          evt_fire;
   logic [8:0]    evt_idx;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic          fifo_full;
   logic          drop;

   // Decode whether the byte sampled this cycle completes a key event
   always_comb begin
      evt_fire = 1'b0;
      evt_new  = '0;
      case (state)
         IDLE: begin
            evt_new = '{brk: 1'b0, ext: 1'b0, code: byte_data};
            evt_fire = (byte_data != EXT) && (byte_data != BRK) &&
                       (byte_data != BAT) && !is_ignored(byte_data);
         end
         GOT_E0: begin
            evt_new = '{brk: 1'b0, ext: 1'b1, code: byte_data};
            evt_fire = (byte_data != BRK) && (byte_data != EXT);
         end
         GOT_F0: begin
            evt_new = '{brk: 1'b1, ext: 1'b0, code: byte_data};
            evt_fire = 1'b1;
         end
         GOT_E0F0: begin
            evt_new = '{brk: 1'b1, ext: 1'b1, code: byte_data};
            evt_fire = 1'b1;
         end
         default: begin
            evt_fire = 1'b0;
         end
      endcase
      if (!byte_valid || byte_err) evt_fire = 1'b0;
   end

   assign evt_idx = {evt_new.ext, evt_new.code};

`ifdef PS2_REPEAT_FILTER_EN
   // Only state changes reach the queue: repeats and orphan breaks are dropped
   assign push = evt_fire && (evt_new.brk ? key_down[evt_idx] : !key_down[evt_idx]);
`else
   assign push = evt_fire;
`endif

   assign evt_valid = !fifo_empty;
   assign pop       = evt_valid && evt_ready;
   assign drop      = push && fifo_full && !pop;
   assign evt_code  = evt_valid ? {head.ext, head.code} : 9'd0;
   assign evt_break = evt_valid && head.brk;

   evt_sync_fifo #(
      .WIDTH (10),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (evt_new),
      .pop   (pop),
      .rdata (head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (evt_count)
   );

   // Parser state, prefix timeout, key bitmap and sticky overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= REQUIRE_BAT ? WAIT_BAT : IDLE;
         kbd_ready <= !REQUIRE_BAT;
         tmo_cnt   <= '0;
         key_down  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;

         if (evt_fire) key_down[evt_idx] <= !evt_new.brk;

         if (state == WAIT_BAT) begin
            if (byte_valid && !byte_err && byte_data == BAT) begin
               state     <= IDLE;
               kbd_ready <= 1'b1;
            end
         end else if (byte_err) begin
            state   <= IDLE;
            tmo_cnt <= '0;
         end else if (byte_valid) begin
            tmo_cnt <= '0;
            case (state)
               IDLE: begin
                  if (byte_data == EXT)      state    <= GOT_E0;
                  else if (byte_data == BRK) state    <= GOT_F0;
                  else if (byte_data == BAT) key_down <= '0;
               end
               GOT_E0: begin
                  if (byte_data == BRK)      state <= GOT_E0F0;
                  else if (byte_data != EXT) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
               state   <= IDLE;
               tmo_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + TW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue: table of single-byte steps plus
// hand-written multi-cycle sequences (timeout, reset, overflow, push/pop, repeat filter).
module tb_ps2_key_event_queue;

   localparam int FIFO_DEPTH     = 4;
   localparam int PREFIX_TIMEOUT = 16;
`ifdef PS2_REPEAT_FILTER_EN
   localparam int EXP_REPEAT_EVTS = 2;
`else
   localparam int EXP_REPEAT_EVTS = 4;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         byte_valid;
   logic [7:0]   byte_data;
   logic         byte_err;
   logic [511:0] key_down;
   logic         evt_valid;
   logic         evt_ready;
   logic [8:0]   evt_code;
   logic         evt_break;
   logic [2:0]   evt_count;
   logic         overflow;
   logic         clr_overflow;
   logic         kbd_ready;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic       valid;
      logic       err;
      logic [7:0] data;
      logic       exp_evt;
      logic [8:0] exp_code;
      logic       exp_brk;
      logic       exp_kbd;
      logic [8:0] key_idx;
      logic       exp_key;
   } vec_t;

   vec_t vecs[$];

   ps2_key_event_queue #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .PREFIX_TIMEOUT (PREFIX_TIMEOUT),
      .REQUIRE_BAT    (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_err     (byte_err),
      .key_down     (key_down),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_code     (evt_code),
      .evt_break    (evt_break),
      .evt_count    (evt_count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .kbd_ready    (kbd_ready)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   function automatic void addVec(input logic v, input logic e, input logic [7:0] d,
                                  input logic ev, input logic [8:0] code, input logic brk,
                                  input logic kbd, input logic [8:0] idx, input logic key);
      vec_t t;
      t.valid = v; t.err = e; t.data = d; t.exp_evt = ev; t.exp_code = code;
      t.exp_brk = brk; t.exp_kbd = kbd; t.key_idx = idx; t.exp_key = key;
      vecs.push_back(t);
   endfunction

   task automatic sendByte(input logic [7:0] b);
      @(negedge clk);
      byte_data  = b;
      byte_valid = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic popOne();
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   task automatic checkHead(input string name, input logic [8:0] code, input logic brk);
      checkOutput({name, " evt_valid"}, int'(evt_valid), 1);
      checkOutput({name, " evt_code"}, int'(evt_code), int'(code));
      checkOutput({name, " evt_break"}, int'(evt_break), int'(brk));
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      @(negedge clk);
      byte_valid = v.valid;
      byte_err   = v.err;
      byte_data  = v.data;
      @(negedge clk);
      byte_valid = 1'b0;
      byte_err   = 1'b0;
      checkOutput($sformatf("vec%0d kbd_ready", idx), int'(kbd_ready), int'(v.exp_kbd));
      checkOutput($sformatf("vec%0d key_down[%0h]", idx, v.key_idx),
                  int'(key_down[v.key_idx]), int'(v.exp_key));
      checkOutput($sformatf("vec%0d evt_count", idx), int'(evt_count), int'(v.exp_evt));
      if (v.exp_evt) begin
         checkHead($sformatf("vec%0d", idx), v.exp_code, v.exp_brk);
         popOne();
      end else begin
         checkOutput($sformatf("vec%0d evt_valid", idx), int'(evt_valid), 0);
      end
   endtask

   initial begin
      logic [7:0] ovf_codes [6];
      ovf_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};

      rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; byte_err = 1'b0;
      evt_ready = 1'b0; clr_overflow = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset evt_valid", int'(evt_valid), 0);
      checkOutput("reset evt_count", int'(evt_count), 0);
      checkOutput("reset evt_code", int'(evt_code), 0);
      checkOutput("reset evt_break", int'(evt_break), 0);
      checkOutput("reset overflow", int'(overflow), 0);
      checkOutput("reset kbd_ready", int'(kbd_ready), 0);
      checkOutput("reset key_down nonzero", int'(key_down != '0), 0);
      rst = 1'b0;

      //     valid err  data   evt  code    brk  kbd  key     keyval
      addVec(1, 0, 8'h1C, 0, 9'h000, 0, 0, 9'h01C, 0);
      addVec(1, 0, 8'hAA, 0, 9'h000, 0, 1, 9'h01C, 0);
      addVec(1, 0, 8'h1C, 1, 9'h01C, 0, 1, 9'h01C, 1);
      addVec(1, 0, 8'hE0, 0, 9'h000, 0, 1, 9'h175, 0);
      addVec(1, 0, 8'h75, 1, 9'h175, 0, 1, 9'h175, 1);
      addVec(1, 0, 8'hE0, 0, 9'h000, 0, 1, 9'h175, 1);
      addVec(1, 0, 8'hF0, 0, 9'h000, 0, 1, 9'h175, 1);
      addVec(1, 0, 8'h75, 1, 9'h175, 1, 1, 9'h175, 0);
      addVec(1, 0, 8'hF0, 0, 9'h000, 0, 1, 9'h01C, 1);
      addVec(1, 0, 8'h1C, 1, 9'h01C, 1, 1, 9'h01C, 0);
      addVec(1, 0, 8'hE0, 0, 9'h000, 0, 1, 9'h074, 0);
      addVec(0, 1, 8'h00, 0, 9'h000, 0, 1, 9'h074, 0);
      addVec(1, 0, 8'h74, 1, 9'h074, 0, 1, 9'h074, 1);
      addVec(1, 0, 8'hFA, 0, 9'h000, 0, 1, 9'h0FA, 0);
      addVec(1, 0, 8'hE0, 0, 9'h000, 0, 1, 9'h16B, 0);
      addVec(1, 0, 8'hE0, 0, 9'h000, 0, 1, 9'h16B, 0);
      addVec(1, 0, 8'h6B, 1, 9'h16B, 0, 1, 9'h16B, 1);
      addVec(1, 0, 8'hF0, 0, 9'h000, 0, 1, 9'h01C, 0);
      addVec(1, 1, 8'h1C, 0, 9'h000, 0, 1, 9'h01C, 0);
      addVec(1, 0, 8'h1C, 1, 9'h01C, 0, 1, 9'h01C, 1);
      addVec(1, 0, 8'hAA, 0, 9'h000, 0, 1, 9'h074, 0);
      addVec(1, 0, 8'hEE, 0, 9'h000, 0, 1, 9'h01C, 0);

      foreach (vecs[i]) applyStimulus(vecs[i], i);

      // Stale F0 expires, so the next byte is a make
      sendByte(8'hF0);
      repeat (PREFIX_TIMEOUT + 2) @(negedge clk);
      sendByte(8'h1C);
      checkHead("timeout make", 9'h01C, 1'b0);
      popOne();
      sendByte(8'hF0);
      repeat (4) @(negedge clk);
      sendByte(8'h1C);
      checkHead("in-time break", 9'h01C, 1'b1);
      popOne();

      // Reset while an event is queued and E0 is pending
      sendByte(8'h2C);
      sendByte(8'hE0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midreset evt_count", int'(evt_count), 0);
      checkOutput("midreset evt_valid", int'(evt_valid), 0);
      checkOutput("midreset key_down[02C]", int'(key_down[9'h02C]), 0);
      checkOutput("midreset kbd_ready", int'(kbd_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      sendByte(8'h74);
      checkOutput("pre-BAT evt_valid", int'(evt_valid), 0);
      sendByte(8'hAA);
      sendByte(8'h74);
      checkHead("post-reset make", 9'h074, 1'b0);
      popOne();

      // Six makes into a four-entry queue with the consumer stalled
      foreach (ovf_codes[i]) sendByte(ovf_codes[i]);
      checkOutput("ovf evt_count", int'(evt_count), 4);
      checkOutput("ovf overflow", int'(overflow), 1);
      checkOutput("ovf key_down[035]", int'(key_down[9'h035]), 1);
      for (int i = 0; i < 4; i++) begin
         checkHead($sformatf("ovf pop%0d", i), {1'b0, ovf_codes[i]}, 1'b0);
         popOne();
      end
      checkOutput("ovf drained evt_valid", int'(evt_valid), 0);
      @(negedge clk);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      checkOutput("ovf cleared", int'(overflow), 0);

      // Full queue: commit and pop on the same edge
      for (int i = 0; i < 4; i++) begin
         sendByte(8'hF0);
         sendByte(ovf_codes[i]);
      end
      checkOutput("full evt_count", int'(evt_count), 4);
      @(negedge clk);
      byte_data = 8'h3C; byte_valid = 1'b1; evt_ready = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0; evt_ready = 1'b0;
      checkOutput("full pushpop evt_count", int'(evt_count), 4);
      checkOutput("full pushpop overflow", int'(overflow), 0);
      for (int i = 1; i < 4; i++) begin
         checkHead($sformatf("full pop%0d", i), {1'b0, ovf_codes[i]}, 1'b1);
         popOne();
      end
      checkHead("full tail", 9'h03C, 1'b0);
      popOne();

      // Empty queue: commit and ready on the same edge keeps the new event
      evt_ready = 1'b1;
      sendByte(8'h43);
      checkOutput("empty pushpop evt_count", int'(evt_count), 1);
      checkHead("empty pushpop", 9'h043, 1'b0);
      @(negedge clk);
      checkOutput("empty pushpop drained", int'(evt_valid), 0);
      evt_ready = 1'b0;

      // Typematic repeats followed by a release
      sendByte(8'h1C);
      sendByte(8'h1C);
      sendByte(8'h1C);
      sendByte(8'hF0);
      sendByte(8'h1C);
      checkOutput("repeat evt_count", int'(evt_count), EXP_REPEAT_EVTS);
      checkOutput("repeat key_down[01C]", int'(key_down[9'h01C]), 0);
      checkOutput("repeat overflow", int'(overflow), 0);
      checkHead("repeat first", 9'h01C, 1'b0);
      repeat (EXP_REPEAT_EVTS) popOne();
      checkOutput("repeat drained", int'(evt_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/ps2_key_event_queue.md
Name: ps2_key_event_queue

Overview:
- Parametrised successor to the keyboard decoder. Parses raw PS/2 scancode bytes (Set 2) from the PS/2 byte receiver into 9-bit key codes {extended, code}.
- Maintains a 512-bit key-down bitmap.
- Queues every make/break event in an internal FIFO with a valid/ready consumer interface, so no key event is lost when the consumer stalls.
- Sits between the PS/2 byte receiver and game/UI logic.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, ≥2.
PREFIX_TIMEOUT, 100000, clk cycles allowed between a prefix byte (E0/F0) and the next byte before the prefix is discarded; ≥1.
REQUIRE_BAT, 1, 1: events are suppressed until a 0xAA self-test byte is seen; 0: the block is live from reset.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
byte_valid  in  1  one-cycle strobe; byte_data is valid
byte_data  in  8  received scancode byte
byte_err  in  1  one-cycle strobe; parity/framing error from the receiver
key_down  out  512  bit k is set while key code k is held
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_code  out  9  head key code {ext, byte}
evt_break  out  1  head is a release (1) or press (0)
evt_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky; an event was dropped because the FIFO was full
clr_overflow  in  1  clears overflow
kbd_ready  out  1  BAT seen (tied to 1 when REQUIRE_BAT=0)

Behaviour:
- Reset values: key_down=0, FIFO empty, evt_valid=0, evt_code=0, evt_break=0, evt_count=0, overflow=0, kbd_ready=0 (1 if REQUIRE_BAT=0).
- Reset state: WAIT_BAT (IDLE if REQUIRE_BAT=0).
- Parser FSM states: WAIT_BAT, IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions occur only on byte_valid, except for timeout and error below.
- WAIT_BAT:
  - 0xAA → IDLE, kbd_ready=1.
  - All other bytes are ignored.
- IDLE:
  - E0 → GOT_E0; F0 → GOT_F0.
  - AA → stay in IDLE and clear key_down (keyboard re-plug). The FIFO is untouched.
  - FA, EE, FE, E1, 00, FF are ignored.
  - Any other byte b → make event {0,b}.
- GOT_E0:
  - F0 → GOT_E0F0.
  - E0 → stay in GOT_E0.
  - Any other byte b → make event {1,b}, then IDLE.
- GOT_F0: byte b → break event {0,b}, then IDLE.
- GOT_E0F0: byte b → break event {1,b}, then IDLE.
- byte_err in any state other than WAIT_BAT → IDLE. No event is generated; key_down is unchanged. If byte_err and byte_valid occur together, byte_err wins.
- Prefix timeout:
  - The counter is cleared on every byte_valid and counts while in GOT_E0, GOT_F0 or GOT_E0F0.
  - When it reaches PREFIX_TIMEOUT → IDLE with no event.
- Event commit:
  - Takes effect on the clk edge that samples the completing byte.
  - key_down[code] is set on a make and cleared on a break, visible the next cycle.
  - The event is written to the FIFO the same edge, so evt_valid rises the following cycle when the FIFO was empty. Latency: 1 cycle.
- FIFO:
  - Pop when evt_valid && evt_ready.
  - A push when full (and no pop that cycle) drops the event and sets overflow; key_down is still updated.
  - Simultaneous push and pop when full: both are accepted and evt_count is unchanged.
  - Simultaneous push and pop when empty: the push is accepted and the pop does nothing.
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_code and evt_break hold the head entry and are stable while evt_valid && !evt_ready.
- overflow: if clr_overflow and a new drop occur in the same cycle, the set wins.
- Reset mid-sequence (for example after E0): the FSM and FIFO are cleared immediately, and no partial event survives.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- Defined:
  - A make for a key already set in key_down (typematic repeat) is not enqueued.
  - A break for a key not set in key_down is not enqueued.
  - key_down is unaffected in both cases.
- Undefined: every decoded make and break is enqueued, repeats included.

Decomposition:
- Package ps2_kbd_pkg holds:
  - byte constants: BAT=8'hAA, EXT=8'hE0, BRK=8'hF0, ACK=8'hFA, ECHO=8'hEE, RESEND=8'hFE, PAUSE=8'hE1;
  - the parser state enum;
  - a packed event struct {break, ext, code[7:0]}.
- Sub-module: evt_sync_fifo, a parametrised single-clock FIFO (width 10, depth FIFO_DEPTH) with count output. The parser and key_down bitmap stay in the top level.

Test Plan:
1. BAT gating: with REQUIRE_BAT=1, send 1C, then AA, then 1C → no event before AA; kbd_ready=1 after AA; then evt {0x01C, break=0}; key_down[0x01C]=1.
2. Extended break: send E0 75, then E0 F0 75 → events {0x175,0} then {0x175,1}; key_down[0x175] ends at 0.
3. Overflow: FIFO_DEPTH=4, evt_ready=0, send 6 makes → evt_count=4, overflow=1; the first 4 codes pop in order; clr_overflow → overflow=0.
4. Prefix timeout and error: send F0, wait PREFIX_TIMEOUT cycles, send 1C → make {0x01C,0}, not a break. Send E0, then a byte_err pulse, then 74 → make {0x074,0}.
5. Full with simultaneous push/pop: FIFO full, evt_ready=1 in the same cycle a new event commits → evt_count unchanged, no overflow, new event at the tail.
6. Repeat filter: with PS2_REPEAT_FILTER_EN defined, send 1C 1C 1C F0 1C → exactly 2 events. With it undefined → 4 events.
